// File: rtl/spi_slave_if_pkg.sv
// Shared constants and helpers for the SPI slave front end.
// SPI_DATA_W / SPI_SYNC_STAGES may be predefined to override the defaults.
`ifndef SPI_DATA_W
`define SPI_DATA_W 8
`endif
`ifndef SPI_SYNC_STAGES
`define SPI_SYNC_STAGES 2
`endif

package spi_slave_if_pkg;

  localparam int   SPI_DATA_W_DEF      = `SPI_DATA_W;
  localparam int   SPI_SYNC_STAGES_DEF = `SPI_SYNC_STAGES;
  localparam logic SPI_IDLE_SCK        = 1'b0;
  localparam logic SPI_IDLE_CS_N       = 1'b1;

  typedef struct packed {
    logic rise;
    logic fall;
  } edges_t;

  function automatic edges_t detect_edges(input logic cur, input logic prev);
    edges_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchronizer for one asynchronous pad; resets to the pad's idle level.
module pad_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // NOTE: resetting to the idle level keeps the first post-reset cycle from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {STAGES{RST_VAL}};
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: synchronizes pads, frames MSB-first words, shifts miso.
// Define SPI_FRAME_ERR_EN to add the spi_frame_err output for aborted words.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF,
  parameter int DATA_W      = SPI_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [DATA_W-1:0] spi_c_data_in,
  output logic              spi_c_data_stb,
  output logic              spi_tsx_start,
  input  logic [DATA_W-1:0] spi_c_data_out,
  output logic              spi_busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              spi_frame_err
`endif
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_s, cs_n_s, mosi_s;
  logic sck_q, cs_n_q;
  edges_t sck_e;
  logic cs_fall, rise_en, fall_en;

  logic [CNT_W-1:0]  bit_cnt;
  // The final bit comes straight from mosi, so only DATA_W-1 bits are ever stored.
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;

  pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_IDLE_SCK)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(spi_sck), .q(sck_s)
  );
  pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_IDLE_CS_N)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s)
  );
  pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
  );

  assign sck_e   = detect_edges(sck_s, sck_q);
  assign cs_fall = ~cs_n_s & cs_n_q;
  // A transaction start takes precedence over a coincident sck rise.
  assign rise_en = sck_e.rise & ~cs_n_s & ~cs_fall;
  assign fall_en = sck_e.fall & ~cs_n_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q          <= SPI_IDLE_SCK;
      cs_n_q         <= SPI_IDLE_CS_N;
      bit_cnt        <= '0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      spi_c_data_in  <= '0;
      spi_c_data_stb <= 1'b0;
      spi_tsx_start  <= 1'b0;
    end else begin
      sck_q          <= sck_s;
      cs_n_q         <= cs_n_s;
      spi_c_data_stb <= 1'b0;
      spi_tsx_start  <= cs_fall;

      if (cs_fall) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (cs_n_s) begin
        bit_cnt <= '0;
      end else if (rise_en) begin
        rx_sr <= {rx_sr[DATA_W-3:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt        <= '0;
          spi_c_data_in  <= {rx_sr, mosi_s};
          spi_c_data_stb <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      // Between words miso follows the controller until the first rise commits the word.
      if (bit_cnt == '0 && !rise_en)
        tx_sr <= spi_c_data_out;
      else if (fall_en)
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spi_frame_err <= 1'b0;
    else        spi_frame_err <= cs_n_s & ~cs_n_q & (bit_cnt != '0);
  end
`endif

  assign spi_miso    = tx_sr[DATA_W-1];
  assign spi_miso_oe = ~cs_n_s;
  assign spi_busy    = ~cs_n_s;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed scenarios plus randomized transfers
// against a transaction-level model (expected words, pulse counts, miso bits).
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n, sck, cs_n, mosi;
  logic       miso, oe, stb, tsx, busy;
  logic [7:0] data_in, data_out;
`ifdef SPI_FRAME_ERR_EN
  logic       ferr;
`endif

  spi_slave_if #(.SYNC_STAGES(2), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(oe), .spi_c_data_in(data_in),
    .spi_c_data_stb(stb), .spi_tsx_start(tsx), .spi_c_data_out(data_out),
    .spi_busy(busy)
`ifdef SPI_FRAME_ERR_EN
    , .spi_frame_err(ferr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_stb = 0, n_tsx = 0, n_ferr = 0;
  int e_words = 0, e_tsx = 0, e_ferr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every strobe must deliver the oldest outstanding complete word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stb) begin
        n_stb++;
        if (exp_q.size() > 0) check("rx_word", {24'h0, data_in}, {24'h0, exp_q.pop_front()});
        else                  check("stb_spurious", 32'd1, 32'd0);
      end
      if (tsx) n_tsx++;
`ifdef SPI_FRAME_ERR_EN
      if (ferr) n_ferr++;
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_lower(input int gap);
    cs_n = 1'b0;
    e_tsx++;
    tick(gap);
  endtask

  task automatic cs_raise(input int gap);
    cs_n = 1'b1;
    tick(gap);
  endtask

  // Shifts nbits of tx; miso is checked at each rise against the word loaded before the first rise.
  // After the last rise's strobe has had time to appear, data_out moves to nxt.
  task automatic send_bits(input logic [7:0] tx, input int nbits, input int ph, input logic [7:0] nxt);
    logic [7:0] m_exp;
    m_exp = data_out;
    if (nbits == 8) begin
      exp_q.push_back(tx);
      e_words++;
      exp_last = tx;
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(ph);
      check("miso_bit", {31'h0, miso}, {31'h0, m_exp[7-i]});
      sck = 1'b1;
      if (i == 7) begin
        tick(5);
        data_out = nxt;
        tick(ph - 5);
      end else begin
        tick(ph);
      end
      sck = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_stb"}, n_stb, e_words);
    check({tag, "_tsx"}, n_tsx, e_tsx);
    check({tag, "_data_hold"}, {24'h0, data_in}, {24'h0, exp_last});
`ifdef SPI_FRAME_ERR_EN
    check({tag, "_ferr"}, n_ferr, e_ferr);
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_outs"}, {24'h0, miso, oe, stb, tsx, busy, 3'b000},
          32'h0);
    check({tag, "_data_in"}, {24'h0, data_in}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; data_out = 8'h00;
    tick(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick(4);

    // 1: single byte 3C, 8 clk per phase
    cs_lower(10);
    check("busy_low_cs", {30'h0, busy, oe}, 32'h3);
    send_bits(8'h3C, 8, 8, 8'hA5);
    cs_raise(8);
    check("idle_oe", {31'h0, oe}, 32'h0);
    check_counts("t1");

    // 2: data_out A5, two bytes of zeros; miso must read A5 on each word
    cs_lower(6);
    send_bits(8'h00, 8, 8, 8'hA5);
    send_bits(8'h00, 8, 8, 8'hA5);
    cs_raise(8);
    check_counts("t2");

    // 3: abort after 5 bits of FF, then a clean 81
    data_out = 8'h5A;
    cs_lower(6);
    send_bits(8'hFF, 5, 7, 8'h5A);
    cs_raise(10);
    e_ferr++;
    check_counts("t3_abort");
    cs_lower(6);
    send_bits(8'h81, 8, 7, 8'h00);
    cs_raise(8);
    check_counts("t3");

    // 4: back-to-back words with data_out changing after every strobe
    data_out = 8'h11;
    cs_lower(6);
    send_bits(8'h00, 8, 8, 8'hE7);
    send_bits(8'hFF, 8, 8, 8'h3C);
    send_bits(8'h55, 8, 8, 8'h00);
    cs_raise(8);
    check_counts("t4");

    // 5: sck activity with cs_n high must be ignored
    for (int i = 0; i < 8; i++) begin
      sck = 1'b1; tick(6);
      sck = 1'b0; tick(6);
      check("t5_oe", {30'h0, oe, busy}, 32'h0);
    end
    check_counts("t5");

    // 6: reset in the middle of a word, then a full C3 transfer
    cs_lower(6);
    send_bits(8'hC3, 4, 6, 8'h00);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sck   = 1'b0;
    tick(1);
    check_zero_outputs("t6_rst");
    tick(3);
    check_zero_outputs("t6_rst_hold");
    rst_n = 1'b1;
    exp_last = 8'h00;
    tick(6);
    check_counts("t6_release");
    cs_lower(6);
    send_bits(8'hC3, 8, 6, 8'h00);
    cs_raise(8);
    check_counts("t6");

    // Randomized transfers: 1-3 words, random phase, optional trailing partial word
    for (int t = 0; t < 20; t++) begin
      int ph, nw;
      ph = $urandom_range(5, 9);
      nw = $urandom_range(1, 3);
      data_out = 8'($urandom);
      cs_lower($urandom_range(5, 12));
      for (int w = 0; w < nw; w++)
        send_bits(8'($urandom), 8, ph, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        send_bits(8'($urandom), $urandom_range(1, 7), ph, data_out);
        e_ferr++;
      end
      cs_raise($urandom_range(6, 12));
    end
    check_counts("random");
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
